alm_mult_arbiter: RTL and testbench

- Shares one signed 8x8 multiplier datapath among NUM_REQ independent requesters.
- Each request selects exact or approximate (enhanced DR-ALM) multiplication.
- Round-robin arbitration, fixed-latency pipeline, response tagged with requester id, single global response backpressure.
- Sits between the PE request ports and the shared multiplier in the accelerator datapath.

---
 rtl/alm_mult_arbiter.sv | 152 +++++++++++++++
 tb/tb_alm_mult_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alm_mult_arbiter.sv
// Round-robin arbiter in front of one shared signed 8x8 multiplier (exact or DR-ALM approximate),
// with a fixed-latency, globally stalled pipeline and id-tagged responses.
module alm_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TRUNC_WIDTH = 6,
  parameter int LAT         = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [8*NUM_REQ-1:0]       i_req_a,
  input  logic [8*NUM_REQ-1:0]       i_req_b,
  input  logic [NUM_REQ-1:0]         i_req_exact,
  output logic                       o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic [15:0]                o_rsp_z,
  input  logic                       i_rsp_ready,
  output logic                       o_busy,
  output logic [15:0]                o_op_cnt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int FW  = TRUNC_WIDTH - 2;
  localparam int NST = LAT - 1;

  function automatic logic [2:0] lead_one(input logic [7:0] m);
    lead_one = '0;
    for (int i = 0; i < 8; i++)
      if (m[i]) lead_one = 3'(i);
  endfunction

  // Mitchell log multiply: each fraction keeps FW bits below the leading one with its LSB
  // forced to 1, which centres the truncation error instead of always rounding down.
  function automatic logic [15:0] enhanced_dr_alm_8bit_signed(input logic signed [7:0] a,
                                                              input logic signed [7:0] b);
    logic [7:0]    ma, mb, na, nb;
    logic [2:0]    ka, kb;
    logic [FW-1:0] fa, fb;
    logic [FW:0]   s;
    logic [3:0]    sh;
    logic [23:0]   p;
    logic [15:0]   mag;
    ma = a[7] ? 8'(-a) : 8'(a);
    mb = b[7] ? 8'(-b) : 8'(b);
    ka = lead_one(ma);
    kb = lead_one(mb);
    na = ma << (3'd7 - ka);
    nb = mb << (3'd7 - kb);
    fa = FW'(na >> (7 - FW)) | FW'(1);
    fb = FW'(nb >> (7 - FW)) | FW'(1);
    s  = {1'b0, fa} + {1'b0, fb};
    sh = {1'b0, ka} + {1'b0, kb};
    if (s[FW]) p = 24'(s) << (sh + 4'd1);
    else       p = 24'({1'b1, s[FW-1:0]}) << sh;
    mag = 16'(p >> FW);
    if (ma == 8'd0 || mb == 8'd0) enhanced_dr_alm_8bit_signed = '0;
    else if (a[7] ^ b[7])         enhanced_dr_alm_8bit_signed = 16'(-mag);
    else                          enhanced_dr_alm_8bit_signed = mag;
  endfunction

  logic [IDW-1:0]    ptr;
  logic              s0_v;
  logic signed [7:0] s0_a, s0_b;
  logic              s0_exact;
  logic [IDW-1:0]    s0_id;
  logic [NST-1:0]    s_v;
  logic [IDW-1:0]    s_id [NST];
  logic [15:0]       s_z  [NST];
  logic [15:0]       op_cnt;

  logic              stall, rsp_hs, found, accept;
  logic [IDW-1:0]    gidx;
  logic [NUM_REQ-1:0] gnt;
  logic signed [15:0] ea, eb;
  logic [15:0]       prod;

  assign stall  = o_rsp_valid & ~i_rsp_ready;
  assign rsp_hs = o_rsp_valid & i_rsp_ready;

  always_comb begin : arb
    logic [IDW-1:0] idx;
    found = 1'b0;
    gidx  = '0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    accept = found & ~stall;
    if (accept) gnt[gidx] = 1'b1;
  end

  assign o_req_ready = gnt;

  assign ea   = $signed({{8{s0_a[7]}}, s0_a});
  assign eb   = $signed({{8{s0_b[7]}}, s0_b});
  assign prod = s0_exact ? 16'(ea * eb) : enhanced_dr_alm_8bit_signed(s0_a, s0_b);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr      <= '0;
      s0_v     <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_exact <= 1'b0;
      s0_id    <= '0;
      s_v      <= '0;
      for (int i = 0; i < NST; i++) begin
        s_id[i] <= '0;
        s_z[i]  <= '0;
      end
      op_cnt   <= '0;
    end else begin
      if (rsp_hs) op_cnt <= op_cnt + 16'd1;
      if (!stall) begin
        s0_v <= accept;
        if (accept) begin
          s0_a     <= i_req_a[8*gidx +: 8];
          s0_b     <= i_req_b[8*gidx +: 8];
          s0_exact <= i_req_exact[gidx];
          s0_id    <= gidx;
          ptr      <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
        // Bubbles move valid only; data registers keep their last payload.
        s_v[0] <= s0_v;
        if (s0_v) begin
          s_id[0] <= s0_id;
          s_z[0]  <= prod;
        end
        for (int i = 1; i < NST; i++) begin
          s_v[i] <= s_v[i-1];
          if (s_v[i-1]) begin
            s_id[i] <= s_id[i-1];
            s_z[i]  <= s_z[i-1];
          end
        end
      end
    end
  end

  assign o_rsp_valid = s_v[NST-1];
  assign o_rsp_id    = s_id[NST-1];
  assign o_rsp_z     = s_z[NST-1];
  assign o_busy      = s0_v | (|s_v);
  assign o_op_cnt    = op_cnt;

endmodule

// File: tb/tb_alm_mult_arbiter.sv
// Bench for alm_mult_arbiter: vector table, hand-written multi-cycle sequences, response scoreboard.
module tb_alm_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TRUNC_WIDTH = 6;
  localparam int LAT = 2;
  localparam int IDW = 2;
  localparam int FW = TRUNC_WIDTH - 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [8*NUM_REQ-1:0] i_req_a, i_req_b;
  logic [NUM_REQ-1:0]   i_req_exact;
  logic                 o_rsp_valid;
  logic [IDW-1:0]       o_rsp_id;
  logic [15:0]          o_rsp_z;
  logic                 i_rsp_ready;
  logic                 o_busy;
  logic [15:0]          o_op_cnt;

  alm_mult_arbiter #(.NUM_REQ(NUM_REQ), .TRUNC_WIDTH(TRUNC_WIDTH), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_exact(i_req_exact),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_z(o_rsp_z),
    .i_rsp_ready(i_rsp_ready), .o_busy(o_busy), .o_op_cnt(o_op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IDW-1:0] id; logic [15:0] z; } rsp_t;
  typedef struct { logic signed [7:0] a; logic signed [7:0] b; logic ex; logic [15:0] z; } vec_t;

  rsp_t        sb[$];
  logic [15:0] drv_exp [NUM_REQ];
  int          n_tests = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer log-domain multiply with truncated fraction and forced LSB.
  function automatic logic [15:0] ref_mult(input logic signed [7:0] a, input logic signed [7:0] b,
                                          input logic ex);
    int ia, ib, ma, mb, ka, kb, fa, fb, s, r;
    ia = a;
    ib = b;
    if (ia == 0 || ib == 0) return 16'h0000;
    if (ex) return 16'(ia * ib);
    ma = (ia < 0) ? -ia : ia;
    mb = (ib < 0) ? -ib : ib;
    ka = 0;
    while ((2 << ka) <= ma) ka++;
    kb = 0;
    while ((2 << kb) <= mb) kb++;
    fa = (((ma - (1 << ka)) * (1 << FW)) / (1 << ka)) | 1;
    fb = (((mb - (1 << kb)) * (1 << FW)) / (1 << kb)) | 1;
    s = fa + fb;
    if (s < (1 << FW)) r = (((1 << FW) + s) << (ka + kb)) / (1 << FW);
    else               r = (s << (ka + kb + 1)) / (1 << FW);
    if ((ia < 0) != (ib < 0)) r = -r;
    return 16'(r);
  endfunction

  task automatic set_req(input int i, input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic ex, input logic [15:0] z);
    i_req_a[8*i +: 8] = a;
    i_req_b[8*i +: 8] = b;
    i_req_exact[i] = ex;
    drv_exp[i] = z;
  endtask

  task automatic rand_req(input int i);
    logic signed [7:0] a, b;
    logic ex;
    a = 8'($urandom);
    b = 8'($urandom);
    ex = 1'($urandom);
    set_req(i, a, b, ex, ref_mult(a, b, ex));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    i_req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_busy) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Monitor: pushes on request acceptance, pops and compares on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot", 32'($countones(o_req_ready) <= 1), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_req_valid[i] && o_req_ready[i]) begin
          sb.push_back('{id: IDW'(i), z: drv_exp[i]});
          acc_cnt++;
        end
      end
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(o_rsp_id), 32'hFFFF_FFFF);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check("rsp_id", 32'(o_rsp_id), 32'(e.id));
          check("rsp_z", 32'(o_rsp_z), 32'(e.z));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    logic [15:0] z0;
    int rr_exp[5];
    int rr2_exp[3];
    int base;

    vecs[0]  = '{a: -8'sd3,   b: 8'sd5,     ex: 1'b1, z: 16'hFFF1};
    vecs[1]  = '{a: 8'sd64,   b: 8'sd64,    ex: 1'b0, z: 16'h1200};
    vecs[2]  = '{a: -8'sd64,  b: 8'sd64,    ex: 1'b0, z: 16'hEE00};
    vecs[3]  = '{a: 8'sd0,    b: 8'sd77,    ex: 1'b0, z: 16'h0000};
    vecs[4]  = '{a: -8'sd128, b: -8'sd128,  ex: 1'b1, z: 16'h4000};
    vecs[5]  = '{a: 8'sd0,    b: -8'sd5,    ex: 1'b1, z: 16'h0000};
    vecs[6]  = '{a: 8'sd77,   b: 8'sd0,     ex: 1'b0, z: 16'h0000};
    vecs[7]  = '{a: 8'sd127,  b: 8'sd127,   ex: 1'b1, z: 16'd16129};
    vecs[8]  = '{a: 8'sd3,    b: 8'sd5,     ex: 1'b0, z: 16'd15};
    vecs[9]  = '{a: 8'sd127,  b: 8'sd127,   ex: 1'b0, z: 16'd15360};
    vecs[10] = '{a: -8'sd128, b: -8'sd128,  ex: 1'b0, z: 16'd18432};
    vecs[11] = '{a: -8'sd1,   b: 8'sd1,     ex: 1'b1, z: 16'hFFFF};
    vecs[12] = '{a: 8'sd1,    b: 8'sd1,     ex: 1'b0, z: 16'h0001};
    vecs[13] = '{a: 8'sd100,  b: -8'sd3,    ex: 1'b0, z: 16'hFEE0};
    rr_exp  = '{0, 1, 2, 3, 0};
    rr2_exp = '{3, 2, 3};

    rst = 1'b1;
    i_req_valid = '0;
    i_req_a = '0;
    i_req_b = '0;
    i_req_exact = '0;
    i_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) drv_exp[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_op_cnt", 32'(o_op_cnt), 32'd0);
    check("rst_rsp_z", 32'(o_rsp_z), 32'd0);
    check("rst_rsp_id", 32'(o_rsp_id), 32'd0);
    check("rst_req_ready", 32'(o_req_ready), 32'd0);

    // Single exact op: latency and hold-after-handshake.
    tick();
    set_req(0, -8'sd3, 8'sd5, 1'b1, 16'hFFF1);
    i_req_valid = 4'b0001;
    @(negedge clk);
    check("exact_grant", 32'(o_req_ready), 32'h1);
    tick();
    i_req_valid = '0;
    @(negedge clk);
    check("lat_early_valid", 32'(o_rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(o_rsp_valid), 32'd1);
    check("lat_z", 32'(o_rsp_z), 32'hFFF1);
    check("lat_id", 32'(o_rsp_id), 32'd0);
    tick();
    check("op_cnt_one", 32'(o_op_cnt), 32'd1);
    check("valid_cleared", 32'(o_rsp_valid), 32'd0);
    check("z_held", 32'(o_rsp_z), 32'hFFF1);

    // Vector table, back-to-back, one requester per vector.
    for (int v = 0; v < 14; v++) begin
      tick();
      set_req(v % NUM_REQ, vecs[v].a, vecs[v].b, vecs[v].ex, vecs[v].z);
      i_req_valid = '0;
      i_req_valid[v % NUM_REQ] = 1'b1;
    end
    tick();
    i_req_valid = '0;
    wait_drain("table_drain", 20);
    check("table_op_cnt", 32'(o_op_cnt), 32'd15);

    // Round robin from reset.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rand_req(i);
    i_req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      check("rr_grant", 32'(o_req_ready), 32'(1 << rr_exp[g]));
      tick();
    end
    i_req_valid = '0;
    tick();
    i_req_valid = 4'b0100;
    @(negedge clk);
    check("rr_grant_req2", 32'(o_req_ready), 32'h4);
    tick();
    i_req_valid = 4'b1100;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      check("rr_grant_23", 32'(o_req_ready), 32'(1 << rr2_exp[g]));
      tick();
    end
    i_req_valid = '0;
    wait_drain("rr_drain", 20);

    // Backpressure: rsp_ready low for cycles 2..5 after the first accept.
    do_reset();
    for (int i = 0; i < 3; i++) rand_req(i);
    i_req_valid = 4'b0001;
    @(negedge clk);
    check("bp_grant0", 32'(o_req_ready), 32'h1);
    tick();
    i_req_valid = 4'b0010;
    @(negedge clk);
    check("bp_grant1", 32'(o_req_ready), 32'h2);
    tick();
    i_req_valid = 4'b0100;
    i_rsp_ready = 1'b0;
    z0 = drv_exp[0];
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      check("bp_ready_zero", 32'(o_req_ready), 32'h0);
      check("bp_valid_held", 32'(o_rsp_valid), 32'd1);
      check("bp_z_held", 32'(o_rsp_z), 32'(z0));
      check("bp_id_held", 32'(o_rsp_id), 32'd0);
      check("bp_busy", 32'(o_busy), 32'd1);
      tick();
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_grant2", 32'(o_req_ready), 32'h4);
    tick();
    i_req_valid = '0;
    wait_drain("bp_drain", 20);
    check("bp_op_cnt", 32'(o_op_cnt), 32'd3);

    // Asynchronous reset one cycle after an accept.
    tick();
    rand_req(1);
    i_req_valid = 4'b0010;
    @(negedge clk);
    check("mid_grant", 32'(o_req_ready), 32'h2);
    tick();
    i_req_valid = '0;
    #2;
    check("mid_busy_before", 32'(o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("mid_busy", 32'(o_busy), 32'd0);
    check("mid_op_cnt", 32'(o_op_cnt), 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mid_no_ghost", 32'(o_rsp_valid), 32'd0);
    end
    tick();
    for (int i = 0; i < NUM_REQ; i++) rand_req(i);
    i_req_valid = 4'b1111;
    @(negedge clk);
    check("mid_next_grant", 32'(o_req_ready), 32'h1);
    tick();
    i_req_valid = '0;
    wait_drain("mid_drain", 20);

    // 65536 handshakes wrap the op counter back to zero.
    do_reset();
    base = acc_cnt;
    for (int c = 0; c < 70000; c++) begin
      if (acc_cnt - base >= 65536) break;
      for (int i = 0; i < NUM_REQ; i++) rand_req(i);
      i_req_valid = 4'b1111;
      tick();
    end
    i_req_valid = '0;
    check("wrap_accepts", 32'(acc_cnt - base), 32'd65536);
    wait_drain("wrap_drain", 20);
    check("wrap_op_cnt", 32'(o_op_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
